// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder_ctrl
//  Purpose  : Sequencer around an external combinational 4-bit adder.
//             Takes W = 4*NIBBLES bit operands over a valid/ready handshake,
//             feeds the adder one nibble per cycle (LSB first), chains the
//             carry and returns the full-width sum/difference with carry-out
//             and signed overflow over a valid/ready output.
//  Revision : 1.0  initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  // operand request
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [4*NIBBLES-1:0] OP_A,
  input  logic [4*NIBBLES-1:0] OP_B,
  input  logic                 SUB,
  // result
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [4*NIBBLES-1:0] RESULT,
  output logic                 CARRY_OUT,
  output logic                 OVERFLOW,
  // external 4-bit adder
  output logic [3:0]           ADD_A,
  output logic [3:0]           ADD_B,
  output logic                 ADD_CIN,
  input  logic [3:0]           ADD_S,
  input  logic                 ADD_COUT
);

  localparam int W    = 4 * NIBBLES;
  // Slice index needs at least one bit even for a single-nibble build.
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q,  state_d;
  logic [IDXW-1:0] idx_q,    idx_d;
  logic            carry_q,  carry_d;
  logic [W-1:0]    a_q,      a_d;
  logic [W-1:0]    b_q,      b_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q,   cout_d;
  logic            ovf_q,    ovf_d;
  logic            ovalid_q, ovalid_d;

  logic            last_slice;

  assign last_slice = (idx_q == C_LAST_IDX);

  // Handshake and result outputs come straight from state; ready is gated
  // by reset so nothing is offered while the block is held in reset.
  assign IN_READY  = RST_N && (state_q == S_IDLE);
  assign OUT_VALID = ovalid_q;
  assign RESULT    = result_q;
  assign CARRY_OUT = cout_q;
  assign OVERFLOW  = ovf_q;

  // Present the current operand slice to the adder; quiet (all zero) outside RUN.
  always_comb begin
    ADD_A   = 4'h0;
    ADD_B   = 4'h0;
    ADD_CIN = 1'b0;
    if (state_q == S_RUN) begin
      ADD_CIN = carry_q;
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx_q == IDXW'(i)) begin
          ADD_A = a_q[4*i +: 4];
          ADD_B = b_q[4*i +: 4];
        end
      end
    end
  end

  // Next-state logic: capture, per-slice accumulate, and result hand-off.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    ovalid_d = ovalid_q;

    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with SUB.
          a_d     = OP_A;
          b_d     = SUB ? ~OP_B : OP_B;
          carry_d = SUB;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDXW'(i)) begin
            result_d[4*i +: 4] = ADD_S;
          end
        end
        carry_d = ADD_COUT;
        if (last_slice) begin
          // Signed overflow: operands share a sign (B taken post-inversion)
          // and the top sum bit disagrees with it.
          cout_d   = ADD_COUT;
          ovf_d    = (a_q[W-1] == b_q[W-1]) && (ADD_S[3] != a_q[W-1]);
          ovalid_d = 1'b1;
          idx_d    = '0;
          state_d  = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      S_DONE: begin
        if (OUT_READY) begin
          ovalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any op.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      ovalid_q <= ovalid_d;
    end
  end

endmodule
`default_nettype wire
